corelet_ctrl: RTL and testbench
===============================

Name: corelet_ctrl

Overview:
- Sequencer that drives the corelet's 35-bit instruction word and the activation/weight SRAM read port for one tile.
- Per tile it loads `row` weight words into L0, shifts them into the MAC array, streams `cfg_len` activation vectors through L0 into the MAC array, then drains the OFIFO through the SFP accumulators.
- Sits between the top-level testbench/host and the corelet/SRAM; tracks L0 occupancy itself so L0 never overflows.

Parameters:
- row, 8, MAC array rows; number of weight words per tile.
- col, 8, MAC array columns; length of the weight-settle phase.
- addr_bw, 11, SRAM address width.
- len_bw, 8, width of the activation count.
- l0_depth, 64, L0 entries; bound for the internal occupancy counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to run a tile; ignored unless state==IDLE.
- cfg_w_base  input  addr_bw  first weight address; sampled on accepted start.
- cfg_x_base  input  addr_bw  first activation address; sampled on accepted start.
- cfg_len  input  len_bw  activation vectors (= OFIFO pops); sampled on accepted start.
- cfg_mode  input  1  value driven on inst[34] for the whole tile; sampled on accepted start.
- l0_full  input  1  L0 full flag; checked only for the error flag.
- ofifo_valid  input  1  OFIFO holds at least one complete column word.
- inst  output  35  corelet instruction word.
- xmem_cen  output  1  SRAM chip enable, active-low.
- xmem_addr  output  addr_bw  SRAM read address.
- busy  output  1  high whenever state!=IDLE.
- done  output  1  one-cycle pulse on DONE.
- err  output  1  sticky flag: l0_full seen while inst[2]=1; cleared by reset or an accepted start.

Behaviour:
- inst mapping:
  - [0] kernel-load.
  - [1] execute.
  - [2] l0_wr.
  - [3] l0_rd.
  - [6] ofifo_rd.
  - [33] sfp acc.
  - [34] mode.
  - All other bits are always 0.
- Reset (also mid-tile): state=IDLE, inst=0, xmem_cen=1, xmem_addr=0, busy=0, done=0, err=0. All counters and occupancy are cleared. A partial tile is abandoned.
- SRAM read latency is 1 cycle. Every read issued in cycle t (xmem_cen=0) produces inst[2]=1 in cycle t+1, unconditionally.
- Occupancy counter `occ`:
  - occ += inst[2]; occ -= inst[3], same cycle.
  - A read may issue only if occ + pending_wr < l0_depth.
  - inst[3] may assert only if occ > 0.
- States:
  - IDLE: all outputs idle. An accepted start latches cfg, clears err, and goes to W_LD.
  - W_LD: issue `row` reads at addresses w_base..w_base+row-1, one per cycle, subject to the occupancy rule. Exit when all `row` writes are complete (last inst[2] seen).
  - K_LD: inst[0]=1 and inst[3]=1 for exactly `row` cycles; occ reaches 0.
  - K_SETTLE: inst=mode bit only, for `col` cycles.
  - X_RUN, with the two sub-activities overlapped:
    - Issue reads x_base..x_base+len-1 under the occupancy rule.
    - In any cycle with occ > 0, assert inst[1]=1 and inst[3]=1.
    - Exit after `len` l0_rd pops.
    - If len==0, go directly to DONE, skipping X_RUN and DRAIN.
  - DRAIN:
    - inst[6]=1 whenever ofifo_valid=1 and fewer than `len` pops have been made.
    - inst[33]=1 in the cycle after each inst[6] (OFIFO output is registered).
    - Exit after the final acc cycle.
  - DONE: done=1 for one cycle, then IDLE.
- inst[34]=latched mode in every non-IDLE state.
- Counters are len_bw+1 bits so len=2^len_bw-1 terminates without wrap. xmem_addr wraps modulo 2^addr_bw.
- start while busy: ignored; cfg is not re-sampled.

Test Plan:
- row=8, cfg_w_base=0, cfg_x_base=16, cfg_len=4, then start → addresses 0..7 then 16..19 seen; 8 inst[2] pulses before K_LD; K_LD lasts 8 cycles; K_SETTLE lasts 8 cycles; 4 inst[1] cycles; done pulses once.
- Same tile with ofifo_valid toggling 1/0 every cycle in DRAIN → exactly 4 inst[6] pulses, each followed next cycle by inst[33]=1; done after the 4th acc.
- l0_depth=4, cfg_len=10 → occ never exceeds 4; no inst[3] with occ=0; err stays 0.
- cfg_len=0 → after K_SETTLE go straight to DONE; inst[1] and inst[6] never assert.
- Assert reset mid X_RUN (after 2 pops) → next cycle inst=0, xmem_cen=1, busy=0; a new start then runs a full tile correctly.
- start pulsed during DRAIN with different cfg → ignored; original tile completes. Separately, force l0_full=1 while inst[2]=1 → err=1 and stays 1 until the next accepted start.

Source files
------------

// File: rtl/corelet_ctrl.sv
// Per-tile sequencer for the corelet instruction word and the activation/weight SRAM read port.
// Keeps its own L0 occupancy count so reads are only issued when L0 has room.
module corelet_ctrl #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int addr_bw  = 11,
    parameter int len_bw   = 8,
    parameter int l0_depth = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] cfg_w_base,
    input  logic [addr_bw-1:0] cfg_x_base,
    input  logic [len_bw-1:0]  cfg_len,
    input  logic               cfg_mode,
    input  logic               l0_full,
    input  logic               ofifo_valid,
    output logic [34:0]        inst,
    output logic               xmem_cen,
    output logic [addr_bw-1:0] xmem_addr,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int RC_MAX = (row > col) ? row : col;
    localparam int CW     = ((len_bw + 1) > ($clog2(RC_MAX) + 1)) ? (len_bw + 1) : ($clog2(RC_MAX) + 1);
    localparam int OW     = $clog2(l0_depth + 1);
    localparam int OW1    = OW + 1;

    localparam logic [CW-1:0] ROW_C = CW'(row);
    localparam logic [CW-1:0] COL_C = CW'(col);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WLD   = 3'd1;
    localparam logic [2:0] S_KLD   = 3'd2;
    localparam logic [2:0] S_KSET  = 3'd3;
    localparam logic [2:0] S_XRUN  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]         state;
    logic [OW-1:0]      occ;
    logic [CW-1:0]      rd_cnt;
    logic [CW-1:0]      pop_cnt;
    logic [CW-1:0]      cnt;
    logic               wr_p1;
    logic               acc_p1;
    logic [addr_bw-1:0] w_base;
    logic [addr_bw-1:0] x_base;
    logic [len_bw-1:0]  len_r;
    logic               mode_r;

    logic [CW-1:0]      len_ext;
    logic [CW-1:0]      rd_limit;
    logic               room;
    logic               rd_issue;
    logic               pop;
    logic               ofifo_rd;
    logic [addr_bw-1:0] rd_addr;

    // A read in flight still owes L0 a slot, so it counts against the room check.
    always_comb begin
        len_ext  = CW'(len_r);
        rd_limit = (state == S_WLD) ? ROW_C : len_ext;
        room     = (OW1'(occ) + OW1'(wr_p1)) < OW1'(l0_depth);
        rd_issue = ((state == S_WLD) || (state == S_XRUN)) && (rd_cnt < rd_limit) && room;
        pop      = (state == S_KLD) || ((state == S_XRUN) && (occ != '0));
        ofifo_rd = (state == S_DRAIN) && ofifo_valid && (pop_cnt < len_ext);
        rd_addr  = ((state == S_WLD) ? w_base : x_base) + addr_bw'(rd_cnt);
    end

    always_comb begin
        inst      = '0;
        inst[0]   = (state == S_KLD);
        inst[1]   = (state == S_XRUN) && pop;
        inst[2]   = wr_p1;
        inst[3]   = pop;
        inst[6]   = ofifo_rd;
        inst[33]  = acc_p1;
        inst[34]  = (state != S_IDLE) && mode_r;
        xmem_cen  = ~rd_issue;
        xmem_addr = rd_issue ? rd_addr : '0;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

    // Stage p1: SRAM data lands in L0 and the registered OFIFO word reaches the SFP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            occ     <= '0;
            wr_p1   <= 1'b0;
            acc_p1  <= 1'b0;
            rd_cnt  <= '0;
            pop_cnt <= '0;
            cnt     <= '0;
            err     <= 1'b0;
        end else begin
            wr_p1  <= rd_issue;
            acc_p1 <= ofifo_rd;
            occ    <= occ + OW'(wr_p1) - OW'(pop);
            if (rd_issue) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if ((state == S_IDLE) && start) begin
                err <= 1'b0;
            end else if (wr_p1 && l0_full) begin
                err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_WLD;
                        rd_cnt  <= '0;
                        pop_cnt <= '0;
                        cnt     <= '0;
                    end
                end
                S_WLD: begin
                    if ((rd_cnt == ROW_C) && wr_p1) begin
                        state  <= S_KLD;
                        rd_cnt <= '0;
                    end
                end
                S_KLD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ROW_C - 1'b1) begin
                        state <= S_KSET;
                        cnt   <= '0;
                    end
                end
                S_KSET: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == COL_C - 1'b1) begin
                        cnt   <= '0;
                        state <= (len_r == '0) ? S_DONE : S_XRUN;
                    end
                end
                S_XRUN: begin
                    if (pop) begin
                        pop_cnt <= pop_cnt + 1'b1;
                        if (pop_cnt == len_ext - 1'b1) begin
                            state   <= S_DRAIN;
                            pop_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (ofifo_rd) begin
                        pop_cnt <= pop_cnt + 1'b1;
                    end
                    if (acc_p1) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == len_ext - 1'b1) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && start && !reset) begin
            w_base <= cfg_w_base;
            x_base <= cfg_x_base;
            len_r  <= cfg_len;
            mode_r <= cfg_mode;
        end
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Randomized bench for corelet_ctrl: two configurations driven in lockstep, each
// checked every cycle against a phase/event-count model of the tile sequence.
`timescale 1ns/1ps
module tb_corelet_ctrl;
    localparam int AW = 11;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_w_base = '0;
    logic [AW-1:0] cfg_x_base = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          cfg_mode = 1'b0;
    logic          l0_full = 1'b0;
    logic          ofifo_valid = 1'b0;

    logic [34:0]   inst0, inst1;
    logic          cen0, cen1;
    logic [AW-1:0] addr0, addr1;
    logic          busy0, busy1, done0, done1, err0, err1;

    int checks = 0;
    int errors = 0;
    int ov_mode = 0;
    int lf_mode = 0;
    bit mon_en = 1'b0;

    int p_row[2] = '{8, 4};
    int p_col[2] = '{8, 2};
    int p_dep[2] = '{64, 4};
    int m_busy[2], m_len[2], m_mode[2], m_wb[2], m_xb[2], err_m[2], done_cnt[2];
    int occ[2], pend[2], n_iss[2], n_wr[2], n_k[2], n_set[2], n_pop[2], n6[2], n33[2], prev6[2], done_due[2];

    always #5 clk = ~clk;

    corelet_ctrl #(.row(8), .col(8), .addr_bw(AW), .len_bw(LW), .l0_depth(64)) u_big (
        .clk(clk), .reset(reset), .start(start), .cfg_w_base(cfg_w_base), .cfg_x_base(cfg_x_base),
        .cfg_len(cfg_len), .cfg_mode(cfg_mode), .l0_full(l0_full), .ofifo_valid(ofifo_valid),
        .inst(inst0), .xmem_cen(cen0), .xmem_addr(addr0), .busy(busy0), .done(done0), .err(err0)
    );

    corelet_ctrl #(.row(4), .col(2), .addr_bw(AW), .len_bw(LW), .l0_depth(4)) u_small (
        .clk(clk), .reset(reset), .start(start), .cfg_w_base(cfg_w_base), .cfg_x_base(cfg_x_base),
        .cfg_len(cfg_len), .cfg_mode(cfg_mode), .l0_full(l0_full), .ofifo_valid(ofifo_valid),
        .inst(inst1), .xmem_cen(cen1), .xmem_addr(addr1), .busy(busy1), .done(done1), .err(err1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr(input int id);
        occ[id] = 0; pend[id] = 0; n_iss[id] = 0; n_wr[id] = 0; n_k[id] = 0; n_set[id] = 0;
        n_pop[id] = 0; n6[id] = 0; n33[id] = 0; prev6[id] = 0; done_due[id] = 0;
    endtask

    // Tile phases are inferred from event counts: writes, kernel-load cycles, settle cycles, pops, OFIFO reads, accs.
    task automatic mon(input int id, input logic [34:0] inst, input logic cen, input logic [AW-1:0] addr,
                       input logic busy, input logic done, input logic err);
        logic [34:0]   e_inst;
        logic          e_cen;
        logic [AW-1:0] e_addr;
        logic          e_done;
        bit            kph, sph, xph, dph, wph;
        string         t;
        e_inst = '0; e_cen = 1'b1; e_addr = '0; e_done = 1'b0;
        kph = 0; sph = 0; xph = 0; dph = 0; wph = 0;
        if (m_busy[id] != 0) begin
            wph = n_wr[id] < p_row[id];
            kph = (n_wr[id] == p_row[id]) && (n_k[id] < p_row[id]);
            sph = (n_k[id] == p_row[id]) && (n_set[id] < p_col[id]);
            xph = (n_k[id] == p_row[id]) && (n_set[id] == p_col[id]) && (n_pop[id] < m_len[id]);
            dph = (n_k[id] == p_row[id]) && (n_set[id] == p_col[id]) && (n_pop[id] == m_len[id]) && (done_due[id] == 0);
            e_inst[34] = (m_mode[id] != 0);
            e_inst[2]  = (pend[id] != 0);
            if ((occ[id] + pend[id] < p_dep[id]) &&
                ((wph && n_iss[id] < p_row[id]) || (xph && n_iss[id] < p_row[id] + m_len[id]))) begin
                e_cen  = 1'b0;
                e_addr = wph ? AW'(m_wb[id] + n_iss[id]) : AW'(m_xb[id] + n_iss[id] - p_row[id]);
            end
            if (kph) begin
                e_inst[0] = 1'b1;
                e_inst[3] = 1'b1;
            end
            if (xph && occ[id] > 0) begin
                e_inst[1] = 1'b1;
                e_inst[3] = 1'b1;
            end
            if (dph) begin
                e_inst[6]  = ofifo_valid && (n6[id] < m_len[id]);
                e_inst[33] = (prev6[id] != 0);
            end
            e_done = (done_due[id] != 0);
        end
        t = $sformatf("u%0d.", id);
        chk({t, "inst"}, 64'(inst), 64'(e_inst));
        chk({t, "cen"},  64'(cen),  64'(e_cen));
        chk({t, "addr"}, 64'(addr), 64'(e_addr));
        chk({t, "busy"}, 64'(busy), 64'(m_busy[id] != 0));
        chk({t, "done"}, 64'(done), 64'(e_done));
        chk({t, "err"},  64'(err),  64'(err_m[id] != 0));
        if (done) done_cnt[id]++;

        if (reset) begin
            clr(id);
            m_busy[id] = 0;
            err_m[id]  = 0;
        end else if (m_busy[id] != 0) begin
            if (!e_cen) n_iss[id]++;
            occ[id] = occ[id] + int'(e_inst[2]) - int'(e_inst[3]);
            if (e_inst[2]) n_wr[id]++;
            if (kph) n_k[id]++;
            if (sph) begin
                n_set[id]++;
                if (n_set[id] == p_col[id] && m_len[id] == 0) done_due[id] = 1;
            end
            if (e_inst[1]) n_pop[id]++;
            if (e_inst[6]) n6[id]++;
            if (e_inst[33]) begin
                n33[id]++;
                if (n33[id] == m_len[id]) done_due[id] = 1;
            end
            prev6[id] = int'(e_inst[6]);
            pend[id]  = int'(!e_cen);
            if (e_inst[2] && l0_full) err_m[id] = 1;
            if (e_done) m_busy[id] = 0;
        end else if (start) begin
            clr(id);
            m_busy[id] = 1;
            m_len[id]  = int'(cfg_len);
            m_mode[id] = int'(cfg_mode);
            m_wb[id]   = int'(cfg_w_base);
            m_xb[id]   = int'(cfg_x_base);
            err_m[id]  = 0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, inst0, cen0, addr0, busy0, done0, err0);
            mon(1, inst1, cen1, addr1, busy1, done1, err1);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ov_mode)
                0:       ofifo_valid = 1'b1;
                1:       ofifo_valid = ~ofifo_valid;
                default: ofifo_valid = 1'($urandom_range(0, 1));
            endcase
            l0_full = (lf_mode != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tile(input int w, input int x, input int l, input int m);
        @(posedge clk);
        #1;
        cfg_w_base = AW'(w);
        cfg_x_base = AW'(x);
        cfg_len    = LW'(l);
        cfg_mode   = m[0];
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy1) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_idle", 64'(n < 3000), 64'd1);
    endtask

    initial begin
        int d0, d1, n;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_inst", 64'(inst0), 64'd0);
        chk("rst_cen",  64'(cen0),  64'd1);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_err",  64'(err0),  64'd0);

        ov_mode = 0;
        d0 = done_cnt[0]; d1 = done_cnt[1];
        tile(0, 16, 4, 1);
        wait_idle();
        chk("t1_done0", 64'(done_cnt[0] - d0), 64'd1);
        chk("t1_done1", 64'(done_cnt[1] - d1), 64'd1);

        ov_mode = 1;
        d0 = done_cnt[0];
        tile(0, 16, 4, 1);
        wait_idle();
        chk("t2_done0", 64'(done_cnt[0] - d0), 64'd1);

        ov_mode = 2;
        tile(5, 100, 10, 0);
        wait_idle();

        tile(7, 30, 0, 1);
        wait_idle();

        ov_mode = 0;
        tile(0, 16, 8, 1);
        n = 0;
        while (n_pop[0] < 2 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_pop2", 64'(n < 500), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_inst", 64'(inst0), 64'd0);
        chk("midrst_cen",  64'(cen0),  64'd1);
        chk("midrst_busy", 64'(busy0), 64'd0);
        d0 = done_cnt[0];
        tile(0, 16, 4, 1);
        wait_idle();
        chk("after_rst_done0", 64'(done_cnt[0] - d0), 64'd1);

        ov_mode = 2;
        d0 = done_cnt[0];
        tile(10, 200, 6, 1);
        n = 0;
        while (!(m_busy[0] != 0 && n_pop[0] == 6) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_drain", 64'(n < 500), 64'd1);
        tile(300, 400, 3, 0);
        wait_idle();
        chk("busy_start_done0", 64'(done_cnt[0] - d0), 64'd1);

        lf_mode = 1;
        tile(0, 0, 3, 0);
        wait_idle();
        lf_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky0", 64'(err0), 64'd1);
        chk("err_sticky1", 64'(err1), 64'd1);
        tile(1, 2, 2, 1);
        chk("err_clear0", 64'(err0), 64'd0);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            ov_mode = $urandom_range(0, 2);
            tile($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 24), $urandom_range(0, 1));
            wait_idle();
        end

        ov_mode = 2;
        d0 = done_cnt[0];
        tile(2044, 2000, 255, 1);
        wait_idle();
        chk("maxlen_done0", 64'(done_cnt[0] - d0), 64'd1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
